// File: rtl/pong_game_ctrl_if.sv
// Pong game controller bus: frame/button/ball inputs
// and serve/score/lives outputs. Slave = controller.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       btn_start;
  logic       paddle_hit;
  logic [8:0] ball_y;
  logic [8:0] paddle_pos;
  logic       ball_run;
  logic       ball_load;
  logic [9:0] serve_x;
  logic [8:0] serve_y;
  logic       serve_dir_x;
  logic [7:0] score;
  logic [2:0] lives;
  logic       game_over;
  logic [2:0] state;

  modport master (
    output frame_tick, btn_start, paddle_hit,
    output ball_y, paddle_pos,
    input  ball_run, ball_load, serve_x,
    input  serve_y, serve_dir_x, score,
    input  lives, game_over, state
  );

  modport slave (
    input  frame_tick, btn_start, paddle_hit,
    input  ball_y, paddle_pos,
    output ball_run, ball_load, serve_x,
    output serve_y, serve_dir_x, score,
    output lives, game_over, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/miss/over, BCD score, lives.
// Ports: i_clk, i_reset (sync, active-high), io_gc (slave bus).
module pong_game_ctrl #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 90,
  parameter int unsigned MISS_Y       = 440,
  parameter int unsigned SERVE_Y      = 400,
  parameter int unsigned SERVE_X_OFS  = 56
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pong_game_ctrl_if.slave  io_gc
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t     r_state;
  logic       r_btn_q;
  logic       r_start_req;
  logic       r_hit_seen;
  logic [7:0] r_cnt;
  logic       r_ball_run;
  logic       r_ball_load;
  logic [9:0] r_serve_x;
  logic       r_dir;
  logic [7:0] r_score;
  logic [2:0] r_lives;
  logic       r_over;

  logic       w_tick;
  logic       w_rise;
  logic       w_miss;
  logic       w_hit;
  logic       w_idle_over;
  logic [9:0] w_serve_x;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  assign w_tick      = io_gc.frame_tick;
  assign w_rise      = io_gc.btn_start & ~r_btn_q;
  assign w_miss      = io_gc.ball_y >= 9'(MISS_Y);
  // hit may land on the tick cycle itself
  assign w_hit       = r_hit_seen | io_gc.paddle_hit;
  assign w_idle_over = (r_state == ST_IDLE) ||
                       (r_state == ST_OVER);
  assign w_serve_x   = {1'b0, io_gc.paddle_pos} +
                       10'(SERVE_X_OFS);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_btn_q     <= 1'b0;
      r_start_req <= 1'b0;
      r_hit_seen  <= 1'b0;
      r_cnt       <= 8'd0;
      r_ball_run  <= 1'b0;
      r_ball_load <= 1'b0;
      r_serve_x   <= 10'd0;
      r_dir       <= 1'b0;
      r_score     <= 8'h00;
      r_lives     <= 3'd0;
      r_over      <= 1'b0;
    end else begin
      r_btn_q     <= io_gc.btn_start;
      r_ball_load <= 1'b0;
      if (w_rise && w_idle_over)
        r_start_req <= 1'b1;
      unique case (r_state)
        ST_IDLE, ST_OVER: begin
          if (r_start_req) begin
            r_start_req <= 1'b0;
            r_score     <= 8'h00;
            r_lives     <= 3'(LIVES_INIT);
            r_over      <= 1'b0;
            r_state     <= ST_SERVE;
            r_ball_load <= 1'b1;
            r_serve_x   <= w_serve_x;
            r_dir       <= ~r_dir;
            r_cnt       <= 8'(SERVE_FRAMES);
          end
        end
        ST_SERVE: begin
          r_serve_x <= w_serve_x;
          if (w_tick) begin
            if (r_cnt <= 8'd1) begin
              r_state    <= ST_PLAY;
              r_ball_run <= 1'b1;
              r_hit_seen <= 1'b0;
              r_cnt      <= 8'd0;
            end else begin
              r_cnt       <= r_cnt - 8'd1;
              r_ball_load <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (io_gc.paddle_hit)
            r_hit_seen <= 1'b1;
          // score is committed on the tick so a
          // miss in the same frame can discard it
          if (w_tick) begin
            r_hit_seen <= 1'b0;
            if (w_miss) begin
              r_ball_run <= 1'b0;
              if (r_lives <= 3'd1) begin
                r_lives <= 3'd0;
                r_state <= ST_OVER;
                r_over  <= 1'b1;
              end else begin
                r_lives <= r_lives - 3'd1;
                r_state <= ST_MISS;
                r_cnt   <= 8'(MISS_FRAMES);
              end
            end else if (w_hit) begin
              r_score <= bcd_inc(r_score);
            end
          end
        end
        ST_MISS: begin
          if (w_tick) begin
            if (r_cnt <= 8'd1) begin
              r_state     <= ST_SERVE;
              r_ball_load <= 1'b1;
              r_serve_x   <= w_serve_x;
              r_dir       <= ~r_dir;
              r_cnt       <= 8'(SERVE_FRAMES);
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_gc.ball_run    = r_ball_run;
  assign io_gc.ball_load   = r_ball_load;
  assign io_gc.serve_x     = r_serve_x;
  assign io_gc.serve_y     = 9'(SERVE_Y);
  assign io_gc.serve_dir_x = r_dir;
  assign io_gc.score       = r_score;
  assign io_gc.lives       = r_lives;
  assign io_gc.game_over   = r_over;
  assign io_gc.state       = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl.
// Linear step sequence with immediate-assertion checks.
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   load_cnt = 0;

  pong_game_ctrl_if gc();

  pong_game_ctrl dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_gc  (gc)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (gc.ball_load === 1'b1) load_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    gc.frame_tick = 1'b1;
    step();
    gc.frame_tick = 1'b0;
    step();
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hit_frame();
    gc.paddle_hit = 1'b1;
    step();
    gc.paddle_hit = 1'b0;
    tick();
  endtask

  initial begin
    gc.frame_tick = 1'b0;
    gc.btn_start  = 1'b0;
    gc.paddle_hit = 1'b0;
    gc.ball_y     = 9'd100;
    gc.paddle_pos = 9'd100;
    step();
    step();
    chk("rst_state", 16'(gc.state), 16'd0);
    chk("rst_run", 16'(gc.ball_run), 16'd0);
    chk("rst_load", 16'(gc.ball_load), 16'd0);
    chk("rst_sx", 16'(gc.serve_x), 16'd0);
    chk("rst_dir", 16'(gc.serve_dir_x), 16'd0);
    chk("rst_score", 16'(gc.score), 16'h00);
    chk("rst_lives", 16'(gc.lives), 16'd0);
    chk("rst_over", 16'(gc.game_over), 16'd0);
    reset = 1'b0;
    ticks(5);
    chk("idle_state", 16'(gc.state), 16'd0);
    chk("idle_lives", 16'(gc.lives), 16'd0);
    chk("idle_nold", 16'(load_cnt), 16'd0);
    chk("serve_y", 16'(gc.serve_y), 16'd400);

    // start: edge registered, then IDLE consumes it
    gc.btn_start = 1'b1;
    step();
    chk("st_wait", 16'(gc.state), 16'd0);
    step();
    chk("sv_state", 16'(gc.state), 16'd1);
    chk("sv_load", 16'(gc.ball_load), 16'd1);
    chk("sv_x", 16'(gc.serve_x), 16'd156);
    chk("sv_dir", 16'(gc.serve_dir_x), 16'd1);
    chk("sv_lives", 16'(gc.lives), 16'd3);
    step();
    chk("sv_pulse", 16'(gc.ball_load), 16'd0);
    gc.frame_tick = 1'b1;
    step();
    chk("sv_reload", 16'(gc.ball_load), 16'd1);
    gc.frame_tick = 1'b0;
    step();
    gc.paddle_pos = 9'd200;
    ticks(58);
    chk("sv_hold", 16'(gc.state), 16'd1);
    chk("sv_track", 16'(gc.serve_x), 16'd256);
    gc.frame_tick = 1'b1;
    step();
    chk("pl_state", 16'(gc.state), 16'd2);
    chk("pl_run", 16'(gc.ball_run), 16'd1);
    chk("pl_noload", 16'(gc.ball_load), 16'd0);
    gc.frame_tick = 1'b0;
    step();

    for (int i = 0; i < 12; i++) hit_frame();
    chk("score12", 16'(gc.score), 16'h12);
    for (int i = 0; i < 3; i++) begin
      gc.paddle_hit = 1'b1;
      step();
      gc.paddle_hit = 1'b0;
      step();
    end
    tick();
    chk("one_per_frame", 16'(gc.score), 16'h13);
    for (int i = 0; i < 86; i++) hit_frame();
    chk("score99", 16'(gc.score), 16'h99);
    hit_frame();
    chk("sat99", 16'(gc.score), 16'h99);

    // miss 1
    gc.ball_y = 9'd440;
    tick();
    gc.ball_y = 9'd100;
    chk("m1_lives", 16'(gc.lives), 16'd2);
    chk("m1_state", 16'(gc.state), 16'd3);
    chk("m1_run", 16'(gc.ball_run), 16'd0);
    ticks(89);
    chk("m1_hold", 16'(gc.state), 16'd3);
    gc.paddle_pos = 9'd300;
    gc.frame_tick = 1'b1;
    step();
    chk("rs_state", 16'(gc.state), 16'd1);
    chk("rs_load", 16'(gc.ball_load), 16'd1);
    chk("rs_dir", 16'(gc.serve_dir_x), 16'd0);
    chk("rs_x", 16'(gc.serve_x), 16'd356);
    gc.frame_tick = 1'b0;
    step();
    ticks(60);
    chk("p2_state", 16'(gc.state), 16'd2);

    // miss 2
    gc.ball_y = 9'd440;
    tick();
    gc.ball_y = 9'd100;
    chk("m2_lives", 16'(gc.lives), 16'd1);
    ticks(150);
    chk("p3_state", 16'(gc.state), 16'd2);
    chk("p3_dir", 16'(gc.serve_dir_x), 16'd1);

    // new edge during play must be ignored
    gc.btn_start = 1'b0;
    step();
    gc.btn_start = 1'b1;
    step();

    // miss 3 -> game over
    gc.ball_y = 9'd440;
    tick();
    gc.ball_y = 9'd100;
    chk("ov_state", 16'(gc.state), 16'd4);
    chk("ov_flag", 16'(gc.game_over), 16'd1);
    chk("ov_lives", 16'(gc.lives), 16'd0);
    chk("ov_run", 16'(gc.ball_run), 16'd0);
    step();
    step();
    step();
    chk("ov_held", 16'(gc.state), 16'd4);

    // restart
    gc.btn_start = 1'b0;
    step();
    gc.btn_start = 1'b1;
    step();
    step();
    chk("re_state", 16'(gc.state), 16'd1);
    chk("re_score", 16'(gc.score), 16'h00);
    chk("re_lives", 16'(gc.lives), 16'd3);
    chk("re_over", 16'(gc.game_over), 16'd0);
    chk("re_load", 16'(gc.ball_load), 16'd1);
    chk("re_dir", 16'(gc.serve_dir_x), 16'd0);
    ticks(60);
    chk("re_play", 16'(gc.state), 16'd2);
    hit_frame();
    chk("re_score1", 16'(gc.score), 16'h01);

    // hit and miss in the same frame
    gc.paddle_hit = 1'b1;
    gc.ball_y = 9'd450;
    step();
    gc.paddle_hit = 1'b0;
    tick();
    gc.ball_y = 9'd100;
    chk("hm_score", 16'(gc.score), 16'h01);
    chk("hm_lives", 16'(gc.lives), 16'd2);
    chk("hm_state", 16'(gc.state), 16'd3);
    ticks(150);
    chk("hm_play", 16'(gc.state), 16'd2);

    // reset mid-game
    reset = 1'b1;
    step();
    chk("mr_state", 16'(gc.state), 16'd0);
    chk("mr_run", 16'(gc.ball_run), 16'd0);
    chk("mr_load", 16'(gc.ball_load), 16'd0);
    chk("mr_sx", 16'(gc.serve_x), 16'd0);
    chk("mr_dir", 16'(gc.serve_dir_x), 16'd0);
    chk("mr_score", 16'(gc.score), 16'h00);
    chk("mr_lives", 16'(gc.lives), 16'd0);
    chk("mr_over", 16'(gc.game_over), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
